// File: rtl/mac_pkg.sv
// Shared constants, state encoding and sizing helpers for the MAC operand feeder.
// Optional tlast checking in the top is enabled by MAC_FEEDER_TLAST_CHECK_EN.
package mac_pkg;

  localparam int DW    = 64;
  localparam int J_DEF = 14;
  localparam int I_DEF = 7;
  localparam int A_DEF = 2;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  localparam int G_DEF = ceil_div(I_DEF, A_DEF);

  typedef enum logic {
    LOAD_V = 1'b0,
    STREAM = 1'b1
  } state_e;

endpackage

// File: rtl/mac_vec_buf.sv
// J x DW register file holding the current vector; one sync write port, one comb read port.
// Contents survive reset so a held vector is never disturbed by the FSM restarting.
module mac_vec_buf #(
  parameter int J  = 14,
  parameter int DW = 64,
  parameter int KW = $clog2(J) + 1
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [KW-1:0] widx_i,
  input  logic [DW-1:0] wdat_i,
  input  logic [KW-1:0] ridx_i,
  output logic [DW-1:0] rdat_o
);

  logic [DW-1:0] mem_q [J];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[widx_i] <= wdat_i;
  end

  assign rdat_o = mem_q[ridx_i];

endmodule

// File: rtl/mac_operand_feeder.sv
// Buffers one vector, then pairs it with G row groups of streamed M slices; 1-cycle accept->output,
// no downstream backpressure. Optional tlast checking port set: MAC_FEEDER_TLAST_CHECK_EN.
module mac_operand_feeder
  import mac_pkg::*;
#(
  parameter int J = J_DEF,
  parameter int I = I_DEF,
  parameter int A = A_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [DW-1:0]   s_v_tdata,
  input  logic            s_v_tvalid,
  output logic            s_v_tready,
  input  logic [A*DW-1:0] s_m_tdata,
  input  logic            s_m_tvalid,
  output logic            s_m_tready,
`ifdef MAC_FEEDER_TLAST_CHECK_EN
  input  logic            s_v_tlast,
  input  logic            s_m_tlast,
  output logic            err,
`endif
  output logic [DW-1:0]   vinput,
  output logic            vinput_tvalid,
  output logic            vinput_tlast,
  output logic [A*DW-1:0] M_row,
  output logic            M_row_tvalid,
  output logic            M_row_tlast,
  output logic            frame_done
);

  localparam int G  = ceil_div(I, A);
  localparam int KW = $clog2(J) + 1;
  localparam int GW = $clog2(G) + 1;
  localparam logic [KW-1:0] K_LAST = KW'(J - 1);
  localparam logic [GW-1:0] G_LAST = GW'(G - 1);

  state_e          state_q, state_d;
  logic [KW-1:0]   v_idx_q, v_idx_d;
  logic [KW-1:0]   k_q, k_d;
  logic [GW-1:0]   g_q, g_d;
  logic            v_rdy_q, m_rdy_q;
  logic [DW-1:0]   vin_q, vin_d;
  logic [A*DW-1:0] mrow_q, mrow_d;
  logic            vld_q, vld_d, last_q, last_d, done_q, done_d;
  logic [A*DW-1:0] lane_mask;
  logic [DW-1:0]   rd_dat;
  logic            v_acc, m_acc;

  // Ready flags are registered so both read 0 while in reset and the first cycle after.
  assign v_acc = s_v_tvalid & v_rdy_q;
  assign m_acc = s_m_tvalid & m_rdy_q;

  mac_vec_buf #(.J(J), .DW(DW), .KW(KW)) u_vbuf (
    .clk    (clk),
    .we_i   (v_acc),
    .widx_i (v_idx_q),
    .wdat_i (s_v_tdata),
    .ridx_i (k_q),
    .rdat_o (rd_dat)
  );

  always_comb begin
    lane_mask = '0;
    for (int a = 0; a < A; a++) begin
      if (int'(g_q) * A + a < I) lane_mask[a*DW +: DW] = '1;
    end
  end

  always_comb begin
    state_d = state_q;
    v_idx_d = v_idx_q;
    k_d     = k_q;
    g_d     = g_q;
    vin_d   = vin_q;
    mrow_d  = mrow_q;
    vld_d   = 1'b0;
    last_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      LOAD_V: begin
        if (v_acc) begin
          if (v_idx_q == K_LAST) begin
            v_idx_d = '0;
            state_d = STREAM;
          end else begin
            v_idx_d = v_idx_q + 1'b1;
          end
        end
      end
      STREAM: begin
        if (m_acc) begin
          vin_d  = rd_dat;
          mrow_d = s_m_tdata & lane_mask;
          vld_d  = 1'b1;
          last_d = (k_q == K_LAST);
          if (k_q == K_LAST) begin
            k_d = '0;
            if (g_q == G_LAST) begin
              g_d     = '0;
              state_d = LOAD_V;
              done_d  = 1'b1;
            end else begin
              g_d = g_q + 1'b1;
            end
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD_V;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD_V;
      v_idx_q <= '0;
      k_q     <= '0;
      g_q     <= '0;
      v_rdy_q <= 1'b0;
      m_rdy_q <= 1'b0;
      vin_q   <= '0;
      mrow_q  <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      v_idx_q <= v_idx_d;
      k_q     <= k_d;
      g_q     <= g_d;
      v_rdy_q <= (state_d == LOAD_V);
      m_rdy_q <= (state_d == STREAM);
      vin_q   <= vin_d;
      mrow_q  <= mrow_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

`ifdef MAC_FEEDER_TLAST_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (v_acc && (s_v_tlast != (v_idx_q == K_LAST))) err_d = 1'b1;
    if (m_acc && (s_m_tlast != ((g_q == G_LAST) && (k_q == K_LAST)))) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`endif

  assign s_v_tready    = v_rdy_q;
  assign s_m_tready    = m_rdy_q;
  assign vinput        = vin_q;
  assign vinput_tvalid = vld_q;
  assign vinput_tlast  = last_q;
  assign M_row         = mrow_q;
  assign M_row_tvalid  = vld_q;
  assign M_row_tlast   = last_q;
  assign frame_done    = done_q;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Bench for mac_operand_feeder: frame-level model plus directed frames with literal pins.
// Build with MAC_FEEDER_TLAST_CHECK_EN to also exercise the err output.
module tb_mac_operand_feeder;

  localparam int J = 14, I = 7, A = 2, G = 4, N = G * J, DW = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [DW-1:0]   s_v_tdata;
  logic            s_v_tvalid;
  logic            s_v_tready;
  logic [A*DW-1:0] s_m_tdata;
  logic            s_m_tvalid;
  logic            s_m_tready;
  logic [DW-1:0]   vinput;
  logic            vinput_tvalid, vinput_tlast;
  logic [A*DW-1:0] M_row;
  logic            M_row_tvalid, M_row_tlast;
  logic            frame_done;
`ifdef MAC_FEEDER_TLAST_CHECK_EN
  logic            s_v_tlast, s_m_tlast, err;
  logic            exp_err;
  int              bad_v = -1;
`endif

  mac_operand_feeder #(.J(J), .I(I), .A(A)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_v_tdata     (s_v_tdata),
    .s_v_tvalid    (s_v_tvalid),
    .s_v_tready    (s_v_tready),
    .s_m_tdata     (s_m_tdata),
    .s_m_tvalid    (s_m_tvalid),
    .s_m_tready    (s_m_tready),
`ifdef MAC_FEEDER_TLAST_CHECK_EN
    .s_v_tlast     (s_v_tlast),
    .s_m_tlast     (s_m_tlast),
    .err           (err),
`endif
    .vinput        (vinput),
    .vinput_tvalid (vinput_tvalid),
    .vinput_tlast  (vinput_tlast),
    .M_row         (M_row),
    .M_row_tvalid  (M_row_tvalid),
    .M_row_tlast   (M_row_tlast),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: beat number n within the frame gives group n/J and element n%J.
  logic [DW-1:0]   mbuf [J];
  int              m_vi, m_n;
  logic            exp_vrdy, exp_mrdy, exp_vld, exp_last, exp_done;
  logic [DW-1:0]   exp_vin;
  logic [A*DW-1:0] exp_mrow;
  wire             mv_acc = s_v_tvalid && exp_vrdy;
  wire             mm_acc = s_m_tvalid && exp_mrdy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vi <= 0; m_n <= 0;
      exp_vrdy <= 1'b0; exp_mrdy <= 1'b0;
      exp_vld <= 1'b0; exp_last <= 1'b0; exp_done <= 1'b0;
      exp_vin <= '0; exp_mrow <= '0;
`ifdef MAC_FEEDER_TLAST_CHECK_EN
      exp_err <= 1'b0;
`endif
    end else begin
      exp_vld  <= mm_acc;
      exp_last <= mm_acc && (m_n % J == J - 1);
      exp_done <= mm_acc && (m_n == N - 1);
      if (mv_acc) begin
        mbuf[m_vi] <= s_v_tdata;
        m_vi <= (m_vi == J - 1) ? 0 : m_vi + 1;
      end
      if (mm_acc) begin
        exp_vin <= mbuf[m_n % J];
        for (int a = 0; a < A; a++)
          exp_mrow[a*DW +: DW] <= ((m_n / J) * A + a < I) ? s_m_tdata[a*DW +: DW] : 64'h0;
        m_n <= (m_n == N - 1) ? 0 : m_n + 1;
      end
      if (mv_acc && m_vi == J - 1) begin
        exp_vrdy <= 1'b0; exp_mrdy <= 1'b1;
      end else if (mm_acc && m_n == N - 1) begin
        exp_vrdy <= 1'b1; exp_mrdy <= 1'b0;
      end else if (!exp_vrdy && !exp_mrdy) begin
        exp_vrdy <= 1'b1;
      end
`ifdef MAC_FEEDER_TLAST_CHECK_EN
      if ((mv_acc && (s_v_tlast != (m_vi == J - 1))) ||
          (mm_acc && (s_m_tlast != (m_n == N - 1))))
        exp_err <= 1'b1;
`endif
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("s_v_tready", s_v_tready, exp_vrdy);
      chk("s_m_tready", s_m_tready, exp_mrdy);
      chk("vinput_tvalid", vinput_tvalid, exp_vld);
      chk("M_row_tvalid", M_row_tvalid, exp_vld);
      chk("vinput_tlast", vinput_tlast, exp_last);
      chk("M_row_tlast", M_row_tlast, exp_last);
      chk("frame_done", frame_done, exp_done);
      if (exp_vld) begin
        chk("vinput", vinput, exp_vin);
        chk("M_row", M_row, exp_mrow);
      end
`ifdef MAC_FEEDER_TLAST_CHECK_EN
      chk("err", err, exp_err);
`endif
    end
  end

  // Output recorder for the literal expectations.
  logic [DW-1:0]   out_vin [$];
  logic [A*DW-1:0] out_m [$];
  bit              out_last [$];
  bit              out_done [$];
  bit              vld_hist [$];

  always @(negedge clk) begin
    vld_hist.push_back(vinput_tvalid);
    if (vinput_tvalid) begin
      out_vin.push_back(vinput);
      out_m.push_back(M_row);
      out_last.push_back(vinput_tlast);
      out_done.push_back(frame_done);
    end
  end

  task automatic clear_rec();
    out_vin.delete(); out_m.delete(); out_last.delete(); out_done.delete(); vld_hist.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [A*DW-1:0] mdat(input int n);
    if (n / J == G - 1) return '1;
    return {32'(n), 32'd1, 32'(n), 32'd0};
  endfunction

  task automatic load_v(input int base);
    for (int i = 0; i < J; i++) begin
      int t;
      s_v_tvalid = 1'b1;
      s_v_tdata  = 64'(base + i);
`ifdef MAC_FEEDER_TLAST_CHECK_EN
      s_v_tlast = (i == J - 1) ^ (i == bad_v);
`endif
      t = 0;
      while (!s_v_tready && t < 50) begin tick(); t++; end
      if (t >= 50) begin chk("v_accept_timeout", 1'b1, 1'b0); s_v_tvalid = 1'b0; return; end
      tick();
    end
    s_v_tvalid = 1'b0;
  endtask

  task automatic stream(input bit gap, input int abort_at);
    for (int n = 0; n < N; n++) begin
      int t;
      if (gap) begin s_m_tvalid = 1'b0; tick(); end
      s_m_tvalid = 1'b1;
      s_m_tdata  = mdat(n);
`ifdef MAC_FEEDER_TLAST_CHECK_EN
      s_m_tlast = (n == N - 1);
`endif
      t = 0;
      while (!s_m_tready && t < 50) begin tick(); t++; end
      if (t >= 50) begin chk("m_accept_timeout", 1'b1, 1'b0); s_m_tvalid = 1'b0; return; end
      tick();
      if (abort_at >= 0 && out_vin.size() >= abort_at) break;
    end
    s_m_tvalid = 1'b0;
    s_v_tvalid = 1'b0;
  endtask

  task automatic check_frame1(input string tag);
    int nlast;
    logic [A*DW-1:0] m;
    nlast = 0;
    chk({tag, "_out_count"}, 32'(out_vin.size()), 32'd56);
    if (out_vin.size() == N) begin
      foreach (out_last[i]) if (out_last[i]) nlast++;
      chk({tag, "_tlast_count"}, 32'(nlast), 32'd4);
      chk({tag, "_tlast13"}, out_last[13], 1'b1);
      chk({tag, "_tlast27"}, out_last[27], 1'b1);
      chk({tag, "_tlast41"}, out_last[41], 1'b1);
      chk({tag, "_tlast55"}, out_last[55], 1'b1);
      chk({tag, "_done55"}, out_done[55], 1'b1);
      chk({tag, "_done54"}, out_done[54], 1'b0);
      chk({tag, "_vin20"}, out_vin[20], 64'd7);
      chk({tag, "_vin55"}, out_vin[55], 64'd14);
      m = out_m[10];
      chk({tag, "_lane1_10"}, m[127:64], 64'h0000_000A_0000_0001);
      m = out_m[50];
      chk({tag, "_g3_lane0"}, m[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
      chk({tag, "_g3_lane1"}, m[127:64], 64'h0);
    end
    chk({tag, "_vrdy_after"}, s_v_tready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int adj, ones;
    rst_n = 1'b0;
    s_v_tdata = '0; s_v_tvalid = 1'b0; s_m_tdata = '0; s_m_tvalid = 1'b0;
`ifdef MAC_FEEDER_TLAST_CHECK_EN
    s_v_tlast = 1'b0; s_m_tlast = 1'b0;
`endif
    repeat (2) tick();
    chk_en = 1'b1;
    chk("rst_vld", vinput_tvalid, 1'b0);
    chk("rst_vrdy", s_v_tready, 1'b0);
    chk("rst_mrdy", s_m_tready, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("vrdy_first_edge", s_v_tready, 1'b1);

    // Back-to-back frame, group 3 all-ones slices.
    load_v(1);
    chk("mrdy_after_load", s_m_tready, 1'b1);
    clear_rec();
    stream(1'b0, -1);
    tick(); tick();
    check_frame1("f1");

    // Alternating bubbles on s_m_tvalid.
    load_v(1);
    clear_rec();
    stream(1'b1, -1);
    tick(); tick();
    adj = 0; ones = 0;
    foreach (vld_hist[i]) begin
      if (vld_hist[i]) ones++;
      if (i > 0 && vld_hist[i] && vld_hist[i-1]) adj++;
    end
    chk("gap_out_count", 32'(ones), 32'd56);
    chk("gap_adjacent", 32'(adj), 32'd0);

    // s_v_tvalid held through STREAM must not touch the buffer.
    load_v(1);
    clear_rec();
    s_v_tvalid = 1'b1;
    s_v_tdata  = 64'hDEAD_BEEF_0000_0000;
    stream(1'b0, -1);
    tick(); tick();
    chk("hold_vin3", out_vin.size() > 3 ? out_vin[3] : 64'hX, 64'd4);
    chk("hold_vin13", out_vin.size() > 13 ? out_vin[13] : 64'hX, 64'd14);
    load_v(101);
    clear_rec();
    stream(1'b0, -1);
    tick(); tick();
    chk("reload_vin0", out_vin.size() > 0 ? out_vin[0] : 64'hX, 64'd101);
    chk("reload_vin27", out_vin.size() > 27 ? out_vin[27] : 64'hX, 64'd114);

    // Asynchronous reset in the middle of a frame.
    load_v(1);
    clear_rec();
    stream(1'b0, 20);
    s_m_tvalid = 1'b0;
    chk("pre_abort_vld", vinput_tvalid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_vld", vinput_tvalid, 1'b0);
    chk("abort_vin", vinput, 64'h0);
    chk("abort_mrow", M_row, 128'h0);
    chk("abort_mrdy", s_m_tready, 1'b0);
    chk("abort_vrdy", s_v_tready, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    load_v(1);
    clear_rec();
    stream(1'b0, -1);
    tick(); tick();
    check_frame1("f5");

`ifdef MAC_FEEDER_TLAST_CHECK_EN
    chk("err_clean", err, 1'b0);
    bad_v = 5;
    load_v(1);
    bad_v = -1;
    chk("err_set", err, 1'b1);
    stream(1'b0, -1);
    tick(); tick();
    chk("err_sticky", err, 1'b1);
`endif

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
